// File: rtl/mux_rr_stream.sv
// rtl/mux_rr_stream.sv - N-channel registered stream mux with fixed-select and round-robin modes
module mux_rr_stream #(
  parameter int CH = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*W-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   out_ch
);

  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          load;
  logic          gnt_v;
  logic [SW-1:0] gnt_idx;

  assign load = !out_valid_q || out_ready;

  // Round-robin search starts one past the last served channel; fixed mode ignores sel >= CH.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = '0;
    if (!mode) begin
      for (int i = 0; i < CH; i++) begin
        if (!gnt_v && sel == SW'(i) && in_valid[i]) begin
          gnt_v   = 1'b1;
          gnt_idx = SW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= CH; k++) begin
        if (!gnt_v && in_valid[(int'(ptr_q) + k) % CH]) begin
          gnt_v   = 1'b1;
          gnt_idx = SW'((int'(ptr_q) + k) % CH);
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CH; i++) begin
      in_ready[i] = !rst && load && gnt_v && (gnt_idx == SW'(i));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (gnt_v) begin
        out_data_d  = in_data[int'(gnt_idx)*W +: W];
        out_valid_d = 1'b1;
        out_ch_d    = gnt_idx;
        ptr_d       = gnt_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      ptr_q       <= SW'(CH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule
